// File: rtl/mdu_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// Holds the mdop encoding, FSM states and helper decoders.
package mdu_ctrl_pkg;

  localparam int MULT_LAT_D = 5;
  localparam int DIV_LAT_D  = 10;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdop_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op == MULT) || (op == MULTU) ||
           (op == DIV)  || (op == DIVU);
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath: {hi,lo} result and div0 flag.
// Ports: i_a, i_b operands, i_mdop op; o_res {hi,lo}, o_div0.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_mdop,
  output logic [63:0] o_res,
  output logic        o_div0
);

  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic               w_bz;
  logic               w_ovf;
  logic [31:0]        w_bs;
  logic [31:0]        w_bu;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;

  assign w_smul = $signed({{32{i_a[31]}}, i_a})
                * $signed({{32{i_b[31]}}, i_b});
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  assign w_bz  = (i_b == 32'd0);
  // Min-int / -1 becomes a / 1: quotient wraps, remainder 0
  assign w_ovf = (i_a == 32'h8000_0000) &&
                 (i_b == 32'hFFFF_FFFF);
  assign w_bs  = (w_bz || w_ovf) ? 32'd1 : i_b;
  assign w_bu  = w_bz ? 32'd1 : i_b;

  assign w_sq = $signed(i_a) / $signed(w_bs);
  assign w_sr = $signed(i_a) % $signed(w_bs);
  assign w_uq = i_a / w_bu;
  assign w_ur = i_a % w_bu;

  assign o_div0 = w_bz && is_div(i_mdop);

  always_comb begin
    o_res = '0;
    unique case (i_mdop)
      MULT:    o_res = w_smul;
      MULTU:   o_res = w_umul;
      DIV:     o_res = {w_sr, w_sq};
      DIVU:    o_res = {w_ur, w_uq};
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage mult/div sequencer owning HI/LO and the busy window.
// Ports: clk, reset, start, mdop, wen, a, b, rsel; busy, hi, lo, rdata.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic        wen,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rsel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_div0;
  logic [63:0]      w_res;
  logic             w_div0;
  logic             w_launch;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;

  mdu_arith u_arith (
    .i_a    (a),
    .i_b    (b),
    .i_mdop (mdop),
    .o_res  (w_res),
    .o_div0 (w_div0)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && is_arith(mdop)) begin
          w_launch    = 1'b1;
          w_state_nxt = RUN;
          w_cnt_nxt   = is_div(mdop)
                      ? CNT_W'(DIV_LAT - 1)
                      : CNT_W'(MULT_LAT - 1);
        end else if (!start && wen) begin
          // start in the same cycle takes priority
          w_mthi = (mdop == MTHI);
          w_mtlo = (mdop == MTLO);
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_pend_div0 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == RUN);
      if (w_launch) begin
        r_pend_hi   <= w_res[63:32];
        r_pend_lo   <= w_res[31:0];
        r_pend_div0 <= w_div0;
      end
      if (w_commit && !r_pend_div0) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign rdata = rsel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus corner sequences.
// Expected HI/LO go through a queue popped when busy falls.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic        wen;
  logic [31:0] a;
  logic [31:0] b;
  logic        rsel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_chk;
  int n_fail;

  logic [63:0] sb_q[$];

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tv[8];

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .wen   (wen),
    .a     (a),
    .b     (b),
    .rsel  (rsel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic run_op(
    input string       nm,
    input logic [2:0]  op,
    input logic [31:0] oa,
    input logic [31:0] ob,
    input logic [31:0] ehi,
    input logic [31:0] elo,
    input int          lat,
    input bit          intrude
  );
    int n;
    logic [63:0] e;
    start = 1'b1;
    mdop  = op;
    a     = oa;
    b     = ob;
    sb_q.push_back({ehi, elo});
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = NONE;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      start = 1'b0;
      mdop  = NONE;
      if (intrude && n == 2) begin
        start = 1'b1;
        mdop  = DIVU;
        a     = 32'd9;
        b     = 32'd3;
      end
    end
    start = 1'b0;
    mdop  = NONE;
    chk({nm, " lat"}, 32'(n), 32'(lat));
    if (sb_q.size() == 0) begin
      chk({nm, " sb"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({nm, " hi"}, hi, e[63:32]);
      chk({nm, " lo"}, lo, e[31:0]);
    end
  endtask

  task automatic mt(
    input logic [2:0]  op,
    input logic [31:0] d
  );
    wen  = 1'b1;
    mdop = op;
    a    = d;
    @(negedge clk);
    wen  = 1'b0;
    mdop = NONE;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mdop   = NONE;
    wen    = 1'b0;
    a      = '0;
    b      = '0;
    rsel   = 1'b0;

    tv[0] = '{"mult", MULT, 32'hFFFF_FFFD, 32'd5,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    tv[1] = '{"multu", MULTU, 32'hFFFF_FFFD, 32'd5,
              32'h0000_0004, 32'hFFFF_FFF1, 5};
    tv[2] = '{"div", DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tv[3] = '{"divu", DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 10};
    tv[4] = '{"divovf", DIV, 32'h8000_0000,
              32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
    tv[5] = '{"divneg", DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 10};
    tv[6] = '{"multmin", MULT, 32'h8000_0000,
              32'h8000_0000, 32'h4000_0000, 32'd0, 5};
    tv[7] = '{"multumax", MULTU, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst rdata", rdata, 32'd0);

    foreach (tv[i])
      run_op(tv[i].nm, tv[i].op, tv[i].a, tv[i].b,
             tv[i].hi, tv[i].lo, tv[i].lat, 1'b0);

    // divide by zero keeps HI/LO
    mt(MTHI, 32'h11);
    mt(MTLO, 32'h22);
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    run_op("div0", DIVU, 32'd7, 32'd0,
           32'h11, 32'h22, 10, 1'b0);

    // MTHI during busy is dropped
    start = 1'b1;
    mdop  = MULT;
    a     = 32'd2;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = NONE;
    @(negedge clk);
    mt(MTHI, 32'hABCD);
    chk("mthi busy", hi, 32'h11);
    repeat (10) begin
      if (busy) @(negedge clk);
    end
    chk("mul23 busy", 32'(busy), 32'd0);
    chk("mul23 lo", lo, 32'd6);
    mt(MTHI, 32'hABCD);
    rsel = 1'b1;
    #1;
    chk("rdata hi", rdata, 32'hABCD);
    rsel = 1'b0;
    #1;
    chk("rdata lo", rdata, 32'd6);

    // reset mid-operation
    start = 1'b1;
    mdop  = MULT;
    a     = 32'hFFFF_FFFD;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = NONE;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid busy", 32'(busy), 32'd0);
    chk("rmid hi", hi, 32'd0);
    chk("rmid lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    chk("rmid late hi", hi, 32'd0);
    chk("rmid late lo", lo, 32'd0);

    // back-to-back, second one with an intruding start
    run_op("b2b1", MULTU, 32'd3, 32'd4,
           32'd0, 32'd12, 5, 1'b0);
    run_op("b2b2", MULT, 32'hFFFF_FFFF, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFF9, 5, 1'b1);
    repeat (12) @(negedge clk);
    chk("intr idle", 32'(busy), 32'd0);
    chk("intr lo", lo, 32'hFFFF_FFF9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencer for the multiply/divide resource in the EX stage. It latches operands on a one-cycle start pulse, holds busy for a fixed latency, and then commits the result to the architectural HI/LO registers. It also serves mthi/mtlo writes and mfhi/mflo reads. Its start and busy outputs feed the hazard unit's md-family stall (stall while start or busy).

Parameters:
MULT_LAT, 5, busy cycles for mult/multu (must be at least 1)
DIV_LAT, 10, busy cycles for div/divu (must be at least 1, and at least MULT_LAT)
CNT_W, $clog2(DIV_LAT+1), width of the latency counter

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse from EX: launch a mult/multu/div/divu
mdop  in  3  operation code (package enum): MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE
wen  in  1  EX qualifier for MTHI/MTLO (write HI/LO from a)
a  in  32  rs operand (dividend, multiplicand, or mthi/mtlo data)
b  in  32  rt operand (divisor or multiplier)
rsel  in  1  read select: 0 = LO (mflo), 1 = HI (mfhi)
busy  out  1  operation in flight (registered)
hi  out  32  architectural HI register
lo  out  32  architectural LO register
rdata  out  32  rsel ? hi : lo (combinational)

Behaviour:
- Reset: busy=0, cnt=0, hi=0, lo=0, pending result=0, state IDLE. Reset mid-operation abandons the operation; HI/LO go to 0 and nothing is committed afterwards.
- FSM states: IDLE and RUN.
- IDLE, start=1 with mdop in {MULT, MULTU, DIV, DIVU}:
  - compute the result from a and b at this edge and hold it as pend_hi/pend_lo;
  - cnt = LAT-1, where LAT is MULT_LAT for multiplies and DIV_LAT for divides;
  - busy=1 and state=RUN from the next cycle.
- Timing: if start is sampled at edge k, busy is 1 during cycles k+1 through k+LAT. At the edge closing cycle k+LAT, hi/lo take the pending values and busy goes to 0 in the same update.
- RUN: cnt decrements once per cycle. When cnt==0, commit and return to IDLE.
- start while busy=1 is a protocol violation that the hazard stall prevents. The block ignores it and the in-flight operation continues.
- start with mdop not in the four arithmetic ops is ignored.
- MTHI/MTLO:
  - when wen=1 and busy=0: write a into hi or lo at the edge, no busy cycles;
  - when wen=1 and busy=1: ignored (the hazard unit stalls md-family instructions).
  - start and wen asserted in the same cycle: start wins and wen is ignored.
- Arithmetic rules:
  - MULT: signed 32x32 to 64, HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0, DIV or DIVU): busy sequencing is unchanged, but the commit is suppressed and HI/LO keep their prior values.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- rdata reflects hi/lo as committed. There is no bypass of the pending value.

Decomposition:
- Shared package (e.g. mips_pkg) holds:
  - the mdop enum encoding (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6);
  - the MULT_LAT and DIV_LAT defaults.
- One sub-module, mdu_arith: purely combinational. Inputs are a, b and mdop; outputs are the 64-bit {hi, lo} result and a div0 flag.
- mdu_ctrl holds the FSM, the counter, the pending registers and HI/LO.

Test Plan:
- Signed mult: a=0xFFFFFFFD, b=5, MULT start at edge k -> busy=1 during cycles k+1 through k+5; after edge k+5, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- MULTU vs DIV: MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> busy for exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: DIVU a=7, b=0 with hi=0x11, lo=0x22 beforehand -> busy for 10 cycles, hi=0x11 and lo=0x22 unchanged afterwards.
- MTHI while busy: MTHI a=0xABCD with wen=1 during busy is ignored; the same request after busy falls -> hi=0xABCD on the next edge; rsel=1 gives rdata=0xABCD.
- Reset mid-operation: reset at cycle k+3 of a MULT -> busy=0, hi=lo=0 on the next edge, and no commit at k+5.
- Back-to-back: second start on the cycle after busy falls -> accepted, busy again for LAT cycles, second result committed; a start asserted while busy is ignored.
